// File: rtl/rv32i_regs_pkg.sv
// Shared register-file types for the integer writeback path.
package rv32i_regs_pkg;
  localparam int XLEN = 32;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef struct packed {
    reg_addr_t        rd;
    logic [XLEN-1:0]  data;
  } wb_result_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy scoreboard with two combinational query ports.
module wb_scoreboard
  import rv32i_regs_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_ena,
  input  reg_addr_t set_addr,
  input  logic      clr_ena,
  input  reg_addr_t clr_addr,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  output logic      rs1_busy,
  output logic      rs2_busy
);
  logic [31:0] busy;

  // The set is written last so it overrides a clear of the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_ena)
        busy[clr_addr] <= 1'b0;
      if (set_ena && set_addr != REG_ZERO)
        busy[set_addr] <= 1'b1;
    end
  end

  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];
endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and LSU results onto the single register-file write port and tracks busy registers.
// Optional write-stage operand bypass is enabled by defining WB_BYPASS_EN.
module regfile_writeback #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [4:0]       lsu_rd,
  input  logic [XLEN-1:0]  lsu_data,
  output logic             wr_ena,
  output logic [4:0]       wr_addr,
  output logic [XLEN-1:0]  wr_data,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rs1_fwd_hit,
  output logic [XLEN-1:0]  rs1_fwd_data,
  output logic             rs2_fwd_hit,
  output logic [XLEN-1:0]  rs2_fwd_data,
  output logic [CNT_W-1:0] wb_count
);
  import rv32i_regs_pkg::*;

  logic       hold_vld;
  wb_result_t hold_q;
  logic       hold_nxt_vld;
  wb_result_t hold_nxt;
  logic       sel_vld;
  wb_result_t sel;
  logic       wr_nxt;
  logic       lsu_acc;
  logic       rs1_busy_raw;
  logic       rs2_busy_raw;

  assign lsu_ready = !hold_vld;
  assign lsu_acc   = lsu_valid && !hold_vld;

  // ALU always wins; a queued or same-cycle load to the same rd is older and is dropped.
  always_comb begin
    sel_vld      = 1'b0;
    sel          = '0;
    hold_nxt_vld = hold_vld;
    hold_nxt     = hold_q;
    if (alu_valid) begin
      sel_vld = 1'b1;
      sel     = '{rd: alu_rd, data: alu_data};
      if (hold_vld && hold_q.rd == alu_rd)
        hold_nxt_vld = 1'b0;
      if (lsu_acc && lsu_rd != alu_rd) begin
        hold_nxt_vld = 1'b1;
        hold_nxt     = '{rd: lsu_rd, data: lsu_data};
      end
    end else if (hold_vld) begin
      sel_vld      = 1'b1;
      sel          = hold_q;
      hold_nxt_vld = 1'b0;
    end else if (lsu_acc) begin
      sel_vld = 1'b1;
      sel     = '{rd: lsu_rd, data: lsu_data};
    end
  end

  assign wr_nxt = sel_vld && sel.rd != REG_ZERO;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld <= 1'b0;
      hold_q   <= '0;
      wr_ena   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wb_count <= '0;
    end else begin
      hold_vld <= hold_nxt_vld;
      hold_q   <= hold_nxt;
      wr_ena   <= wr_nxt;
      if (wr_nxt) begin
        wr_addr  <= sel.rd;
        wr_data  <= sel.data;
        wb_count <= wb_count + CNT_W'(1);
      end
    end
  end

  wb_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_ena  (issue_valid),
    .set_addr (issue_rd),
    .clr_ena  (wr_nxt),
    .clr_addr (sel.rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (rs1_busy_raw),
    .rs2_busy (rs2_busy_raw)
  );

`ifdef WB_BYPASS_EN
  assign rs1_fwd_hit  = wr_ena && wr_addr == rs1 && rs1 != REG_ZERO;
  assign rs2_fwd_hit  = wr_ena && wr_addr == rs2 && rs2 != REG_ZERO;
  assign rs1_fwd_data = rs1_fwd_hit ? wr_data : '0;
  assign rs2_fwd_data = rs2_fwd_hit ? wr_data : '0;
  assign rs1_busy     = rs1_busy_raw && !rs1_fwd_hit;
  assign rs2_busy     = rs2_busy_raw && !rs2_fwd_hit;
`else
  assign rs1_fwd_hit  = 1'b0;
  assign rs2_fwd_hit  = 1'b0;
  assign rs1_fwd_data = '0;
  assign rs2_fwd_data = '0;
  assign rs1_busy     = rs1_busy_raw;
  assign rs2_busy     = rs2_busy_raw;
`endif
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer side of the integer register file: collects completed results and drives the file's single write channel (wr_ena/wr_addr/wr_data), one write per cycle.
- Two result sources:
  - ALU: single-cycle, never back-pressured.
  - LSU: variable latency, valid/ready.
- Keeps a per-register busy scoreboard that the hazard unit queries for two source operands.

Parameters:
- XLEN, 32, data width of results and write channel.
- CNT_W, 16, width of the retired-write counter.

Ports:
- clk  in  1  clock; register file writes on the following negedge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  an instruction with a destination register issues this cycle.
- issue_rd  in  5  destination of the issuing instruction.
- alu_valid  in  1  ALU result present; always accepted.
- alu_rd  in  5  ALU destination.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  LSU result present.
- lsu_ready  out  1  LSU result accepted when lsu_valid && lsu_ready.
- lsu_rd  in  5  LSU destination.
- lsu_data  in  XLEN  LSU load data.
- wr_ena  out  1  register file write enable.
- wr_addr  out  5  register file write address.
- wr_data  out  XLEN  register file write data.
- rs1  in  5  hazard query address 0.
- rs2  in  5  hazard query address 1.
- rs1_busy  out  1  rs1 has an outstanding write; combinational.
- rs2_busy  out  1  rs2 has an outstanding write; combinational.
- rs1_fwd_hit  out  1  bypass hit for rs1 (see Optional Feature).
- rs1_fwd_data  out  XLEN  bypass data for rs1.
- rs2_fwd_hit  out  1  bypass hit for rs2.
- rs2_fwd_data  out  XLEN  bypass data for rs2.
- wb_count  out  CNT_W  number of writes performed.

Behaviour:
- Reset:
  - wr_ena=0, wr_addr=0, wr_data=0, wb_count=0.
  - busy[31:0]=0.
  - Hold buffer empty, so lsu_ready=1.
  - Reset mid-operation drops the hold buffer and any pending write.
- Write stage: wr_* is a registered output. A result accepted in cycle N appears on wr_* in cycle N+1 for exactly one cycle.
- Selection priority each cycle: ALU, then hold buffer, then new LSU result.
- Hold buffer (1 entry):
  - An LSU result accepted in the same cycle as alu_valid goes to the hold buffer.
  - lsu_ready = !hold_valid.
  - The hold buffer drains on the first cycle with no alu_valid.
- Stale kill: if alu_valid && hold_valid && alu_rd==hold_rd, the hold entry is discarded, because the ALU result is younger.
  - The same rule applies to an LSU result arriving in the same cycle with the same rd: it is accepted and dropped.
- x0 handling:
  - A selected result with rd==0 produces wr_ena=0 and is not counted.
  - busy[0] is never set; rs*_busy for address 0 is always 0.
- Scoreboard:
  - issue_valid with issue_rd!=0 sets busy[issue_rd] at posedge.
  - At the posedge where wr_ena rises for address r, busy[r] is cleared.
  - Same register set and cleared at the same edge: set wins.
  - Single outstanding write per register is guaranteed by the hazard unit stalling WAW on busy.
- wb_count increments on every cycle with wr_ena=1 and wraps at 2^CNT_W.
- rs*_busy reads the busy vector directly; no same-cycle bypass of issue.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - rsK_fwd_hit=1 when the current wr_ena && wr_addr==rsK && rsK!=0; rsK_fwd_data=wr_data.
  - On a hit, rsK_busy is forced to 0.
- Undefined: fwd_hit=0, fwd_data=0, and busy is unmodified.
- Ports are present in both builds.

Decomposition:
- Package rv32i_regs_pkg holds:
  - typedef reg_addr_t (5 bits);
  - constant REG_ZERO=5'd0;
  - typedef wb_result_t struct {reg_addr_t rd; logic [XLEN-1:0] data;}.
- Sub-module wb_scoreboard: 32-bit busy vector, set/clear/priority logic, and the two query ports.

Test Plan:
- Reset, then alu_valid with rd=5, data=0x1234 in cycle 0 -> wr_ena=1, wr_addr=5, wr_data=0x1234 in cycle 1; wb_count=1.
- ALU rd=3 data=0xA and LSU rd=7 data=0xB in the same cycle -> cycle 1 writes x3; lsu_ready=0 in cycle 1; cycle 2 writes x7=0xB; lsu_ready=1 in cycle 2.
- Hold buffer holds rd=9 and ALU rd=9 data=0x55 arrives -> only x9=0x55 is written; the stale load never appears; wb_count+1.
- issue rd=12 -> rs1=12 gives rs1_busy=1; LSU result rd=12 accepted -> busy clears the edge wr_ena rises. With WB_BYPASS_EN, during the write cycle rs1_fwd_hit=1, rs1_fwd_data=data, rs1_busy=0.
- alu_valid rd=0 data=0xFFFF -> wr_ena stays 0, wb_count unchanged; issue rd=0 -> rs1=0 busy stays 0.
- Hold buffer full, assert rst asynchronously -> wr_ena=0 immediately, lsu_ready=1, busy=0, no later write of the held entry.
